// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: FSM state codes, parity
// selectors, legal oversampling ratios and the tick-counter width.
package uart_rx_pkg;

    localparam int unsigned EDGE_W = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [EDGE_W-1:0] PRESC_8  = 6'd8;
    localparam logic [EDGE_W-1:0] PRESC_16 = 6'd16;
    localparam logic [EDGE_W-1:0] PRESC_32 = 6'd32;

    // Parity bit the transmitter should have sent for a word whose XOR is data_xor.
    function automatic logic expected_parity(input logic data_xor, input logic typ);
        return data_xor ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Per-bit tick counter: counts oversampling ticks within a bit and bits
// within a frame; held at zero whenever enable is low.
module uart_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned BIT_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [EDGE_W-1:0] presc_q,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              bit_end
);

    // Depends only on registered state so the controller may use it to build enable.
    assign bit_end = (edge_count == presc_q - EDGE_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!enable) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (bit_end) begin
            edge_count <= '0;
            bit_count  <= bit_count + BIT_W'(1);
        end else begin
            edge_count <= edge_count + EDGE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, LSB-first deserialisation,
// parity/stop checking and one-cycle result strobes.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [EDGE_W-1:0]     Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [EDGE_W-1:0]     edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 4);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [EDGE_W-1:0]     presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_flag;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_W-1:0]      bit_count;
    logic                  bit_end;
    logic                  cnt_enable;

    // Counter clears on the same edge the FSM leaves or enters IDLE, so it
    // reads zero for the whole IDLE stay and at cycle 0 of each frame.
    assign cnt_enable = (state != ST_IDLE) && (state_next != ST_IDLE);

    uart_edge_bit_counter #(
        .BIT_W(BIT_W)
    ) u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (cnt_enable),
        .presc_q    (presc_q),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!RX_IN) state_next = ST_START;
            ST_START:  if (bit_end) state_next = sampled_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && (bit_count == BIT_W'(DATA_WIDTH)))
                           state_next = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP:   if (bit_end) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            presc_q     <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            par_flag    <= 1'b0;
            shift       <= '0;
            dat_samp_en <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            state       <= state_next;
            dat_samp_en <= (state_next != ST_IDLE);
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!RX_IN) begin
                        presc_q   <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_flag  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                end
                ST_PARITY: begin
                    if (bit_end) par_flag <= (sampled_bit != expected_parity(^shift, par_typ_q));
                end
                ST_STOP: begin
                    if (bit_end) begin
                        par_err <= par_flag;
                        stp_err <= !sampled_bit;
                        if (!par_flag && sampled_bit) begin
                            data_valid <= 1'b1;
                            P_DATA     <= shift;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       dat_samp_en;
    logic [5:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_count  (edge_count),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int strobe_cnt = 0;
    always @(negedge CLK) if (data_valid || par_err || stp_err) strobe_cnt <= strobe_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] model_pdata = 8'h00;

    typedef struct {
        logic [7:0] data;
        int         p;
        bit         pen, ptyp, pbit, sbit;
        bit         exp_dv, exp_pe, exp_se;
        logic [7:0] exp_pdata;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d required completion", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int rand_presc();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Frame-level reference: outcome depends only on the ones count and the line bits.
    task automatic ref_frame(input logic [7:0] data, input bit pen, ptyp, pbit, sbit,
                             output bit dv, output bit pe, output bit se);
        pe = pen && ((($countones(data) + int'(pbit)) % 2) != int'(ptyp));
        se = !sbit;
        dv = !pe && !se;
    endtask

    // Drives one frame from detection; returns at the strobe cycle (N*P).
    task automatic send_frame(input logic [7:0] data, input int p, input bit pen, ptyp, pbit, sbit,
                              input bit noisy, output int snap);
        logic [11:0] bits;
        int n;
        logic b;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        n = pen ? 11 : 10;
        if (pen) bits[9] = pbit;
        bits[n-1] = sbit;
        Prescale = 6'(p);
        PAR_EN = pen;
        PAR_TYP = ptyp;
        RX_IN = 1'b0;
        sampled_bit = 1'b0;
        tick();
        snap = strobe_cnt;
        for (int c = 0; c < n * p; c++) begin
            if (c == 0) begin
                chk("dat_samp_en at cycle 0", dat_samp_en, 1);
                chk("edge_count at cycle 0", edge_count, 0);
            end
            if (c == n * p - 1) chk("edge_count at stop bit end", edge_count, p - 1);
            b = bits[c / p];
            RX_IN = b;
            sampled_bit = (noisy && (c % p != p - 1)) ? 1'($urandom) : b;
            if (noisy && c == 1) begin
                Prescale = 6'(rand_presc());
                PAR_EN = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            tick();
        end
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
    endtask

    task automatic check_frame(input string name, input int snap, input bit dv, pe, se,
                               input logic [7:0] pd);
        chk({name, " no early strobe"}, strobe_cnt, snap);
        chk({name, " data_valid"}, data_valid, dv);
        chk({name, " par_err"}, par_err, pe);
        chk({name, " stp_err"}, stp_err, se);
        chk({name, " P_DATA"}, P_DATA, pd);
        chk({name, " dat_samp_en low"}, dat_samp_en, 0);
    endtask

    initial begin
        int snap;
        bit dv, pe, se;
        logic [7:0] d;
        int p;
        bit pen, ptyp, pbit, sbit;

        tbl[0] = '{8'hA5, 8,  0, 0, 0, 1, 1, 0, 0, 8'hA5};
        tbl[1] = '{8'h3C, 16, 1, 0, 0, 1, 1, 0, 0, 8'h3C};
        tbl[2] = '{8'h3C, 16, 1, 0, 1, 1, 0, 1, 0, 8'h3C};
        tbl[3] = '{8'h81, 32, 1, 1, 1, 0, 0, 0, 1, 8'h3C};

        #12;
        chk("reset dat_samp_en", dat_samp_en, 0);
        chk("reset edge_count", edge_count, 0);
        chk("reset P_DATA", P_DATA, 0);
        chk("reset strobes", {data_valid, par_err, stp_err}, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].data, tbl[i].p, tbl[i].pen, tbl[i].ptyp, tbl[i].pbit, tbl[i].sbit, 0, snap);
            check_frame($sformatf("table[%0d]", i), snap, tbl[i].exp_dv, tbl[i].exp_pe,
                        tbl[i].exp_se, tbl[i].exp_pdata);
            repeat (3) tick();
        end
        model_pdata = 8'h3C;

        // Start-bit glitch: line low for 3 cycles, sampler reports 1 at bit end.
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        sampled_bit = 1'b0;
        tick();
        snap = strobe_cnt;
        chk("glitch dat_samp_en cycle 0", dat_samp_en, 1);
        tick();
        tick();
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        repeat (5) tick();
        chk("glitch edge_count cycle 7", edge_count, 7);
        tick();
        chk("glitch dat_samp_en cycle 8", dat_samp_en, 0);
        chk("glitch edge_count cycle 8", edge_count, 0);
        repeat (2) tick();
        chk("glitch no strobes", strobe_cnt, snap);
        chk("glitch P_DATA kept", P_DATA, model_pdata);

        // Back-to-back frames with zero idle gap.
        send_frame(8'h55, 8, 0, 0, 0, 1, 0, snap);
        check_frame("b2b first", snap, 1, 0, 0, 8'h55);
        send_frame(8'hF0, 8, 0, 0, 0, 1, 0, snap);
        check_frame("b2b second", snap, 1, 0, 0, 8'hF0);
        model_pdata = 8'hF0;

        // Randomized frames; sampler output is noise except at bit end, and
        // frame parameters change mid-frame.
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            p = rand_presc();
            pen = 1'($urandom);
            ptyp = 1'($urandom);
            pbit = 1'($urandom);
            sbit = ($urandom_range(0, 3) != 0);
            ref_frame(d, pen, ptyp, pbit, sbit, dv, pe, se);
            if (dv) model_pdata = d;
            send_frame(d, p, pen, ptyp, pbit, sbit, 1, snap);
            check_frame($sformatf("random[%0d]", i), snap, dv, pe, se, model_pdata);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset in the middle of a frame.
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        sampled_bit = 1'b0;
        tick();
        repeat (40) tick();
        chk("pre-reset dat_samp_en", dat_samp_en, 1);
        RST = 1'b0;
        #1;
        chk("mid reset dat_samp_en", dat_samp_en, 0);
        chk("mid reset edge_count", edge_count, 0);
        chk("mid reset P_DATA", P_DATA, 0);
        chk("mid reset strobes", {data_valid, par_err, stp_err}, 0);
        model_pdata = 8'h00;
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        snap = strobe_cnt;
        repeat (45) tick();
        chk("aborted frame no strobe", strobe_cnt, snap);
        send_frame(8'h12, 8, 0, 0, 0, 1, 0, snap);
        check_frame("after reset", snap, 1, 0, 0, 8'h12);
        snap = strobe_cnt;
        tick();
        chk("strobe width one cycle", {data_valid, par_err, stp_err}, 0);
        repeat (2) tick();
        chk("no trailing strobe", strobe_cnt, snap + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX path. It detects the start-bit falling edge and runs the per-bit edge counter. It gates the majority-vote data sampler and consumes its `sampled_bit`. It then deserialises LSB-first data, checks parity and stop bit, and presents a parallel word with a one-cycle valid strobe. It sits between the pad-synchronised `RX_IN` and the RX-to-system handoff, alongside the sampler it sequences.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLK` input 1: oversampling clock, Prescale ticks per bit.
- `RST` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line, synchronised, idle high.
- `Prescale` input 6: oversampling ratio. Legal values are 8, 16 and 32.
- `PAR_EN` input 1: 1 means a parity bit follows the data.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd.
- `sampled_bit` input 1: majority-voted bit from the sampler.
- `dat_samp_en` output 1: sampler enable.
- `edge_count` output 6: tick index within the current bit, 0..Prescale-1.
- `P_DATA` output DATA_WIDTH: last good received word.
- `data_valid` output 1: one-cycle strobe when `P_DATA` is updated.
- `par_err` output 1: one-cycle parity-error strobe.
- `stp_err` output 1: one-cycle stop-bit-error strobe.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP. Encoding is one-hot or binary, taken from the package.
- **IDLE:**
  - `edge_count`=0, bit counter=0, `dat_samp_en`=0.
  - `RX_IN`=0 sampled at a clock edge moves to START and latches Prescale into `presc_q`.
- **Tick and bit counting:**
  - In START, DATA, PARITY and STOP, `edge_count` increments every cycle and wraps from `presc_q`-1 to 0.
  - The bit counter increments on each wrap.
  - "Bit end" means the cycle with `edge_count`==`presc_q`-1. `sampled_bit` is read only at bit end.
- **START:** at bit end, `sampled_bit`=1 is a glitch and returns to IDLE with no strobes. `sampled_bit`=0 moves to DATA.
- **DATA:**
  - At each bit end, shift `sampled_bit` into the shift register MSB-first, so the first received bit lands in bit 0.
  - After bit DATA_WIDTH-1, move to PARITY if `PAR_EN`=1, otherwise to STOP.
- **PARITY:**
  - Expected bit = XOR of shift register XOR `PAR_TYP`.
  - At bit end, a mismatch sets the internal flag `par_flag`. Then move to STOP.
- **STOP:**
  - At bit end, `sampled_bit`=0 sets the stop-error condition. Then return to IDLE.
  - In the following cycle:
    - `par_err` pulses if `par_flag` is set.
    - `stp_err` pulses on a stop error.
    - Otherwise `data_valid` pulses and `P_DATA` is loaded from the shift register.
- **Error frames:** `P_DATA` is unchanged on any error frame. `data_valid` and the error strobes are mutually exclusive; `par_err` and `stp_err` may assert together.
- **Mid-frame inputs:** `PAR_EN`, `PAR_TYP` and `Prescale` changes mid-frame are ignored for `Prescale`. `PAR_EN`/`PAR_TYP` are sampled at START entry.
- **Illegal Prescale:** behaviour for illegal Prescale values is undefined, but the FSM must still return to IDLE within one frame.

## Timing
- **Reset:** `RST` low clears everything immediately to state IDLE; all outputs are 0, including `P_DATA`=0. Reset mid-frame aborts the frame with no strobe.
- **Cycle 0** is the first START cycle, with `edge_count`=0.
- **Frame latency:** bit count N = 1 + DATA_WIDTH + `PAR_EN` + 1. The STOP bit end is cycle N·P-1, and strobes fire in cycle N·P.
  - Example: 8N1 at P=8 strobes at cycle 80.
- **Back-to-back frames:** IDLE is re-entered at cycle N·P and a low `RX_IN` is accepted in that same cycle. Next-frame detection therefore coincides with the previous strobe cycle.
- **Sampler enable:** `dat_samp_en` is registered and high for exactly the cycles in START through STOP.

## Structure
- **Package `uart_rx_pkg`:**
  - state enumeration
  - `PAR_EVEN`/`PAR_ODD` constants
  - legal Prescale constants (8, 16, 32)
  - `EDGE_W`=6
- **Sub-module `uart_edge_bit_counter`:**
  - inputs: `enable`, `presc_q`
  - outputs: `edge_count`, `bit_count`, `bit_end`
  - the FSM, parity checker and shift register stay in `uart_rx_ctrl`

## Test plan
- 8N1, P=8, byte 0xA5 sent LSB-first -> `data_valid` for 1 cycle at cycle 80, `P_DATA`=0xA5, no error strobes.
- 8E1, P=16, byte 0x3C with parity 0 -> `data_valid` at cycle 176. Repeat with parity bit 1 -> `par_err` pulse, `P_DATA` keeps 0x3C.
- 8O1, P=32, byte 0x81, stop bit forced 0 -> `stp_err` pulse at cycle 352, no `data_valid`.
- `RX_IN` low for 3 cycles then high, P=8 -> return to IDLE at cycle 8, no strobes, `dat_samp_en` low at cycle 8.
- Two 8N1 frames, 0x55 then 0xF0, with zero idle gap at P=8 -> two `data_valid` strobes 80 cycles apart, with correct words.
- `RST` asserted at cycle 40 of a frame -> all outputs 0 immediately. The next clean frame 0x12 is received correctly.
